// File: rtl/othello_turn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : othello_turn_ctrl_if
// Brief    : Request/strobe bundle between the game caller, the turn
//            controller and the board store.
// Revision : 1.0 - initial release
// ============================================================================
interface othello_turn_ctrl_if;
  // Requests and board feedback (caller -> controller)
  logic       place;
  logic       pass;
  logic [2:0] x_in;
  logic [2:0] y_in;
  logic [7:0] dir;
  // Move coordinates, strobes and status (controller -> caller/board)
  logic [2:0] x;
  logic [2:0] y;
  logic [1:0] side;
  logic       detecten;
  logic       writeen;
  logic       busy;
  logic       invalid;
  logic       done;
  logic       gameover;
  logic [5:0] movecount;

  modport master (
    output place, pass, x_in, y_in, dir,
    input  x, y, side, detecten, writeen, busy, invalid, done, gameover, movecount
  );

  modport slave (
    input  place, pass, x_in, y_in, dir,
    output x, y, side, detecten, writeen, busy, invalid, done, gameover, movecount
  );
endinterface
`default_nettype wire

// File: rtl/othello_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : othello_turn_ctrl
// Brief    : Othello turn sequencer. Latches a move, strobes the board store
//            to detect flippable directions, waits, checks, strobes the write,
//            then hands the turn over. Two back-to-back passes or MAX_MOVES
//            accepted placements end the game.
// Revision : 1.0 - initial release
// ============================================================================
module othello_turn_ctrl #(
  parameter int DET_WAIT  = 2,
  parameter int WR_WAIT   = 2,
  parameter int MAX_MOVES = 60
) (
  input  logic                clock,
  input  logic                resetn,
  othello_turn_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DETECT = 3'd1,
    S_DWAIT  = 3'd2,
    S_CHECK  = 3'd3,
    S_WRITE  = 3'd4,
    S_WWAIT  = 3'd5,
    S_SWAP   = 3'd6,
    S_OVER   = 3'd7
  } state_t;

  localparam logic [3:0] c_det_wait  = 4'(DET_WAIT);
  localparam logic [3:0] c_wr_wait   = 4'(WR_WAIT);
  localparam logic [6:0] c_max_moves = 7'(MAX_MOVES);

  state_t     state_q, state_d;
  logic [2:0] x_q, x_d, y_q, y_d;
  logic [1:0] side_q, side_d;
  logic [5:0] movecount_q, movecount_d;
  logic [1:0] passcnt_q, passcnt_d;
  logic [3:0] wait_q, wait_d;
  logic       dir_ok_q, dir_ok_d;
  logic       detecten_q, detecten_d;
  logic       writeen_q, writeen_d;
  logic       busy_q, busy_d;
  logic       invalid_q, invalid_d;
  logic       done_q, done_d;
  logic       gameover_q, gameover_d;
  logic [6:0] movecount_inc;

  // Next-state and next-output decode; outputs are registered from the next state
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    side_d        = side_q;
    movecount_d   = movecount_q;
    passcnt_d     = passcnt_q;
    wait_d        = wait_q;
    dir_ok_d      = dir_ok_q;
    invalid_d     = 1'b0;
    movecount_inc = {1'b0, movecount_q} + 7'd1;

    case (state_q)
      S_IDLE: begin
        // place has priority over pass when both are requested
        if (bus.place) begin
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          state_d = S_DETECT;
        end else if (bus.pass) begin
          side_d    = {side_q[1], ~side_q[0]};
          passcnt_d = passcnt_q + 2'd1;
          if (passcnt_q == 2'd1) state_d = S_OVER;
        end
      end
      S_DETECT: begin
        wait_d  = c_det_wait;
        state_d = S_DWAIT;
      end
      S_DWAIT: begin
        // dir is sampled on the last wait cycle so invalid can be a registered pulse in CHECK
        if (wait_q <= 4'd1) begin
          dir_ok_d  = |bus.dir;
          invalid_d = ~|bus.dir;
          state_d   = S_CHECK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_CHECK: begin
        state_d = dir_ok_q ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        wait_d  = c_wr_wait;
        state_d = S_WWAIT;
      end
      S_WWAIT: begin
        if (wait_q <= 4'd1) state_d = S_SWAP;
        else                wait_d  = wait_q - 4'd1;
      end
      S_SWAP: begin
        side_d      = {side_q[1], ~side_q[0]};
        movecount_d = (movecount_q == 6'd63) ? 6'd63 : movecount_inc[5:0];
        passcnt_d   = 2'd0;
        state_d     = (movecount_inc == c_max_moves) ? S_OVER : S_IDLE;
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    detecten_d = (state_d == S_DETECT);
    writeen_d  = (state_d == S_WRITE);
    done_d     = (state_d == S_SWAP);
    gameover_d = (state_d == S_OVER);
    busy_d     = (state_d != S_IDLE) && (state_d != S_OVER);
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q     <= S_IDLE;
      x_q         <= 3'd0;
      y_q         <= 3'd0;
      side_q      <= 2'd2;
      movecount_q <= 6'd0;
      passcnt_q   <= 2'd0;
      wait_q      <= 4'd0;
      dir_ok_q    <= 1'b0;
      detecten_q  <= 1'b0;
      writeen_q   <= 1'b0;
      busy_q      <= 1'b0;
      invalid_q   <= 1'b0;
      done_q      <= 1'b0;
      gameover_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      side_q      <= side_d;
      movecount_q <= movecount_d;
      passcnt_q   <= passcnt_d;
      wait_q      <= wait_d;
      dir_ok_q    <= dir_ok_d;
      detecten_q  <= detecten_d;
      writeen_q   <= writeen_d;
      busy_q      <= busy_d;
      invalid_q   <= invalid_d;
      done_q      <= done_d;
      gameover_q  <= gameover_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.side      = side_q;
  assign bus.movecount = movecount_q;
  assign bus.detecten  = detecten_q;
  assign bus.writeen   = writeen_q;
  assign bus.busy      = busy_q;
  assign bus.invalid   = invalid_q;
  assign bus.done      = done_q;
  assign bus.gameover  = gameover_q;

endmodule
`default_nettype wire

// File: tb/tb_othello_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_othello_turn_ctrl
// Brief    : Directed self-checking bench for othello_turn_ctrl. One instance
//            with default parameters, one with MAX_MOVES=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_othello_turn_ctrl;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  othello_turn_ctrl_if bus  ();
  othello_turn_ctrl_if bus2 ();

  othello_turn_ctrl #(.DET_WAIT(2), .WR_WAIT(2), .MAX_MOVES(60)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  othello_turn_ctrl #(.DET_WAIT(2), .WR_WAIT(2), .MAX_MOVES(2)) dut2 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus2)
  );

  always #5 clock = ~clock;

  // One comparison: count it, report on mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accepted move on the default instance, cycle-by-cycle strobe checks.
  // k counts cycles after the one in which place was sampled.
  task automatic accepted_move(input logic [2:0] xi, input logic [2:0] yi, input bit inj_pass);
    bus.place = 1'b1;
    bus.x_in  = xi;
    bus.y_in  = yi;
    bus.dir   = 8'h04;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) bus.place = 1'b0;
      if (inj_pass && k == 3) bus.pass = 1'b1;
      if (k == 4) bus.pass = 1'b0;
      check($sformatf("mv_det_k%0d", k),  bus.detecten, (k == 1));
      check($sformatf("mv_wr_k%0d", k),   bus.writeen,  (k == 5));
      check($sformatf("mv_done_k%0d", k), bus.done,     (k == 8));
      check($sformatf("mv_busy_k%0d", k), bus.busy,     (k <= 8));
      if (k <= 8) begin
        check($sformatf("mv_x_k%0d", k), bus.x, xi);
        check($sformatf("mv_y_k%0d", k), bus.y, yi);
      end
    end
  endtask

  initial begin
    bus.place  = 1'b0; bus.pass  = 1'b0; bus.x_in  = 3'd0; bus.y_in  = 3'd0; bus.dir  = 8'h00;
    bus2.place = 1'b0; bus2.pass = 1'b0; bus2.x_in = 3'd0; bus2.y_in = 3'd0; bus2.dir = 8'h00;

    // Reset state, with place/pass requested during reset
    bus.place = 1'b1; bus.pass = 1'b1;
    tick(); tick();
    check("rst_side", bus.side, 2'd2);
    check("rst_x", bus.x, 3'd0);
    check("rst_y", bus.y, 3'd0);
    check("rst_mc", bus.movecount, 6'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_det", bus.detecten, 1'b0);
    check("rst_wr", bus.writeen, 1'b0);
    check("rst_inv", bus.invalid, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_go", bus.gameover, 1'b0);
    bus.place = 1'b0; bus.pass = 1'b0;
    resetn = 1'b0;
    tick();

    // Accepted move at (3,2); a pass pulse while busy must be ignored
    accepted_move(3'd3, 3'd2, 1'b1);
    check("mv1_side", bus.side, 2'd3);
    check("mv1_mc", bus.movecount, 6'd1);
    check("mv1_go", bus.gameover, 1'b0);

    // Rejected move: invalid at k=4, idle at k=5, nothing else changes
    bus.place = 1'b1; bus.x_in = 3'd5; bus.y_in = 3'd1; bus.dir = 8'h00;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) bus.place = 1'b0;
      check($sformatf("bad_inv_k%0d", k),  bus.invalid, (k == 4));
      check($sformatf("bad_wr_k%0d", k),   bus.writeen, 1'b0);
      check($sformatf("bad_busy_k%0d", k), bus.busy,    (k <= 4));
    end
    check("bad_side", bus.side, 2'd3);
    check("bad_mc", bus.movecount, 6'd1);
    check("bad_x", bus.x, 3'd5);

    // Pass, accepted move, pass: the move clears the pass count
    bus.pass = 1'b1;
    tick();
    bus.pass = 1'b0;
    check("p1_side", bus.side, 2'd2);
    check("p1_go", bus.gameover, 1'b0);
    accepted_move(3'd4, 3'd4, 1'b0);
    check("mv2_side", bus.side, 2'd3);
    check("mv2_mc", bus.movecount, 6'd2);
    bus.pass = 1'b1;
    tick();
    bus.pass = 1'b0;
    check("p2_side", bus.side, 2'd2);
    check("p2_go", bus.gameover, 1'b0);
    tick();
    check("p2_go_late", bus.gameover, 1'b0);

    // Fresh game: two consecutive passes end it; later place ignored
    resetn = 1'b1; tick(); resetn = 1'b0;
    bus.pass = 1'b1;
    tick();
    check("pp1_side", bus.side, 2'd3);
    check("pp1_go", bus.gameover, 1'b0);
    tick();
    bus.pass = 1'b0;
    check("pp2_side", bus.side, 2'd2);
    check("pp2_go", bus.gameover, 1'b1);
    check("pp2_busy", bus.busy, 1'b0);
    bus.place = 1'b1; bus.x_in = 3'd7; bus.y_in = 3'd7; bus.dir = 8'h04;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("ovr_det_k%0d", k), bus.detecten, 1'b0);
      check($sformatf("ovr_go_k%0d", k),  bus.gameover, 1'b1);
    end
    check("ovr_x", bus.x, 3'd0);
    bus.place = 1'b0;

    // MAX_MOVES=2 instance: gameover the cycle after the second done
    resetn = 1'b1; tick(); resetn = 1'b0;
    for (int m = 1; m <= 2; m++) begin
      bus2.place = 1'b1; bus2.x_in = 3'd1; bus2.y_in = 3'd1; bus2.dir = 8'h01;
      for (int k = 1; k <= 9; k++) begin
        tick();
        if (k == 1) bus2.place = 1'b0;
        check($sformatf("mx_done_m%0d_k%0d", m, k), bus2.done, (k == 8));
        check($sformatf("mx_go_m%0d_k%0d", m, k),   bus2.gameover, (m == 2 && k == 9));
      end
      check($sformatf("mx_mc_m%0d", m), bus2.movecount, 6'(m));
    end
    check("mx_busy", bus2.busy, 1'b0);
    bus2.place = 1'b1; bus2.x_in = 3'd6;
    tick(); tick();
    check("mx_ign_det", bus2.detecten, 1'b0);
    check("mx_ign_x", bus2.x, 3'd1);
    bus2.place = 1'b0;

    // Reset mid-WWAIT aborts the move
    resetn = 1'b1; tick(); resetn = 1'b0;
    bus.place = 1'b1; bus.x_in = 3'd3; bus.y_in = 3'd2; bus.dir = 8'h04;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) bus.place = 1'b0;
    end
    check("ab_pre_busy", bus.busy, 1'b1);
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    check("ab_busy", bus.busy, 1'b0);
    check("ab_side", bus.side, 2'd2);
    check("ab_mc", bus.movecount, 6'd0);
    check("ab_x", bus.x, 3'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("ab_wr_k%0d", k),   bus.writeen, 1'b0);
      check($sformatf("ab_done_k%0d", k), bus.done, 1'b0);
      check($sformatf("ab_busy_k%0d", k), bus.busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
